// File: rtl/uart_if_pkg.sv
// Shared types and defaults for the UART-to-ALU command interface.
package uart_if_pkg;

  localparam int unsigned NB_DATA_DEF        = 8;
  localparam int unsigned NB_OP_DEF          = 6;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_B    = 3'd1,
    WAIT_OP   = 3'd2,
    CALC      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/inter_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while running, pulses o_expired on the last allowed cycle.
module inter_byte_timer
  import uart_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the same cycle suppresses expiry, so an arriving byte always wins.
  assign o_expired = i_run && !i_clear && (count == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear || o_expired) begin
      count <= '0;
    end else if (i_run) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU and returns its result byte.
module uart_alu_interface
  import uart_if_pkg::*;
#(
  parameter int unsigned NB_DATA        = NB_DATA_DEF,
  parameter int unsigned NB_OP          = NB_OP_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_drop
);

  state_t state, state_next;

  logic [NB_DATA-1:0] data_a_next, data_b_next, tx_data_next;
  logic [NB_OP-1:0]   op_next;
  logic               tx_start_next, timeout_next, drop_next;

  logic waiting, timer_run, timer_clear, expired;

  assign waiting     = (state == WAIT_B) || (state == WAIT_OP);
  assign timer_run   = waiting && !i_rx_done;
  assign timer_clear = !waiting || i_rx_done;

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_run     (timer_run),
    .i_clear   (timer_clear),
    .o_expired (expired)
  );

  always_comb begin
    state_next    = state;
    data_a_next   = o_data_a;
    data_b_next   = o_data_b;
    op_next       = o_op;
    tx_data_next  = o_tx_data;
    tx_start_next = 1'b0;
    timeout_next  = 1'b0;
    drop_next     = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_done) begin
          data_a_next = i_rx_data;
          state_next  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          data_b_next = i_rx_data;
          state_next  = WAIT_OP;
        end else if (expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          op_next    = i_rx_data[NB_OP-1:0];
          state_next = CALC;
        end else if (expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      CALC: begin
        tx_data_next  = i_alu_result;
        tx_start_next = 1'b1;
        drop_next     = i_rx_done;
        state_next    = WAIT_DONE;
      end
      WAIT_DONE: begin
        drop_next = i_rx_done;
        if (i_tx_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      state      <= state_next;
      o_data_a   <= data_a_next;
      o_data_b   <= data_b_next;
      o_op       <= op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_busy     <= (state_next != IDLE);
      o_timeout  <= timeout_next;
      o_drop     <= drop_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface with an A+B ALU model and a short inter-byte timeout.
module tb_uart_alu_interface;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0;
  logic               rx_done = 1'b0;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic [NB_DATA-1:0] data_a, data_b;
  logic [NB_OP-1:0]   op;
  logic               busy, timeout, drop;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned tmo_seen = 0;
  int unsigned drop_seen = 0;
  logic [NB_DATA-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign alu_result = data_a + data_b;

  uart_alu_interface #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_result),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op        (op),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_drop      (drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every transmit request must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (timeout) tmo_seen++;
      if (drop) drop_seen++;
    end
  end

  task automatic send_byte(input logic [NB_DATA-1:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [5:0] exp_op, input logic [7:0] exp_res);
    exp_q.push_back(exp_res);
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    check("op_a", {24'd0, data_a}, {24'd0, a});
    check("op_b", {24'd0, data_b}, {24'd0, b});
    check("opcode", {26'd0, op}, {26'd0, exp_op});
    check("start_early", {31'd0, tx_start}, 32'd0);
    @(posedge clk); #1;
    check("start_pulse", {31'd0, tx_start}, 32'd1);
    check("tx_data_direct", {24'd0, tx_data}, {24'd0, exp_res});
    @(posedge clk); #1;
    check("start_cleared", {31'd0, tx_start}, 32'd0);
    check("busy_wait_done", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_tx;
    repeat (2) @(posedge clk);
    #1;
    tx_done = 1'b1;
    check("busy_before_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    tx_done = 1'b0;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tx_data, data_a, data_b, 2'b00, op},  32'd0);
    check("rst_flags", {28'd0, tx_start, busy, timeout, drop}, 32'd0);
    rst_n = 1'b1;

    // Basic command, A+B
    issue_cmd(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
    finish_tx();

    // Partial command abandoned by timeout
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (timeout) break;
    end
    check("timeout_cycles", n, 32'd100);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_keep_a", {24'd0, data_a}, 32'h11);
    check("timeout_keep_b", {24'd0, data_b}, 32'h22);
    @(posedge clk); #1;
    check("timeout_pulse_end", {31'd0, timeout}, 32'd0);

    // tx_done outside WAIT_DONE is ignored
    send_byte(8'hAA);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    check("tx_done_ignored", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'hAB);
    send_byte(8'h01);
    send_byte(8'h20);
    check("after_timeout_a", {24'd0, data_a}, 32'hAA);
    repeat (2) @(posedge clk);
    finish_tx();

    // Opcode masking, then an extra byte during transmit
    issue_cmd(8'h02, 8'h04, 8'hE3, 6'h23, 8'h06);
    send_byte(8'h7F);
    check("drop_pulse", {31'd0, drop}, 32'd1);
    check("drop_keep_a", {24'd0, data_a}, 32'h02);
    check("drop_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("drop_pulse_end", {31'd0, drop}, 32'd0);
    finish_tx();
    issue_cmd(8'h10, 8'h20, 8'h20, 6'h20, 8'h30);
    finish_tx();

    // Asynchronous reset between byte 2 and byte 3
    send_byte(8'h33);
    send_byte(8'h44);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {tx_data, data_a, data_b, 2'b00, op}, 32'd0);
    check("midrst_flags", {28'd0, tx_start, busy, timeout, drop}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_cmd(8'h01, 8'h01, 8'h20, 6'h20, 8'h02);
    finish_tx();

    // Byte arrives on exactly the expiry cycle in WAIT_B
    send_byte(8'h55);
    repeat (98) @(posedge clk);
    send_byte(8'h66);
    check("edge_no_timeout", {31'd0, timeout}, 32'd0);
    check("edge_b_accepted", {24'd0, data_b}, 32'h66);
    check("edge_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'hBB);
    send_byte(8'h20);
    repeat (2) @(posedge clk);
    finish_tx();

    repeat (3) @(posedge clk);
    check("timeouts_total", tmo_seen, 32'd1);
    check("drops_total", drop_seen, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
